// File: rtl/popcnt_job_sched.sv
// rtl/popcnt_job_sched.sv - round-robin job scheduler sharing one pipelined popcount unit
module popcnt_job_sched #(
  parameter int NREQ = 2,
  parameter int LAT  = 8,
  parameter int CW   = 16,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_last,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [31:0]          pc_in,
  input  logic [5:0]           pc_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [CW-1:0]        res_count,
  output logic                 res_sat,
  output logic                 busy
);

  // Requester vectors are padded to a power of two so the grant index selects them exactly.
  localparam int NPAD = 1 << IDW;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

  state_t            state_q;
  logic [IDW-1:0]    grant_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [31:0]       pc_in_q;
  // Stage 0 lines up with the word on pc_in, stage LAT with its count on pc_out.
  logic [LAT:0]      vpipe_q, vpipe_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              res_valid_q;
  logic [IDW-1:0]    res_id_q;
  logic [CW-1:0]     res_count_q;
  logic              res_sat_q;
  logic              busy_q;

  logic [NPAD-1:0]    valid_ext;
  logic [NPAD-1:0]    last_ext;
  logic [32*NPAD-1:0] data_ext;
  logic               g_valid, g_last, accept, pipe_drained;
  logic [31:0]        g_word;
  logic               any_valid;
  logic [IDW-1:0]     pick;
  logic [IDW-1:0]     rr_next;
  logic [CW:0]        sum;

  assign valid_ext = NPAD'(req_valid);
  assign last_ext  = NPAD'(req_last);
  assign data_ext  = (32*NPAD)'(req_data);

  assign g_valid = valid_ext[grant_q];
  assign g_last  = last_ext[grant_q];
  assign g_word  = data_ext[{grant_q, 5'b0} +: 32];
  // req_ready[g] is high exactly while in STREAM, so this is the valid&ready handshake.
  assign accept  = (state_q == STREAM) && g_valid;

  // Everything younger than the tail is empty: the tail count (if any) is the last add.
  assign pipe_drained = (vpipe_q[LAT-1:0] == '0);
  assign rr_next      = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);

  // Cyclic search for the first requesting client at or after rr_ptr.
  always_comb begin
    int j;
    any_valid = 1'b0;
    pick      = rr_ptr_q;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any_valid && valid_ext[IDW'(j)]) begin
        any_valid = 1'b1;
        pick      = IDW'(j);
      end
    end
  end

  // Valid-pipe shift and saturating accumulation of returned counts.
  always_comb begin
    vpipe_d = {vpipe_q[LAT-1:0], accept};
    sum     = {1'b0, acc_q} + {{(CW-5){1'b0}}, pc_out};
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (vpipe_q[LAT]) begin
      if (sum[CW]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[CW-1:0];
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      req_ready_q <= '0;
      pc_in_q     <= '0;
      vpipe_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_count_q <= '0;
      res_sat_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      if (accept) pc_in_q <= g_word;

      case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_q     <= pick;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            req_ready_q <= NREQ'(1) << pick;
            busy_q      <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (accept && g_last) begin
            req_ready_q <= '0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_drained) begin
            res_count_q <= acc_d;
            res_sat_q   <= sat_d;
            res_id_q    <= grant_q;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr_q    <= rr_next;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign pc_in     = pc_in_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;
  assign res_sat   = res_sat_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_popcnt_job_sched.sv
// tb/tb_popcnt_job_sched.sv - directed self-checking bench for popcnt_job_sched
module tb_popcnt_job_sched;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last;
  logic [63:0] req_data;
  logic        res_ready;

  logic [1:0]  req_ready_a, req_ready_b;
  logic [31:0] pc_in_a, pc_in_b;
  logic [5:0]  pc_out_a, pc_out_b;
  logic        res_valid_a, res_valid_b;
  logic        res_id_a, res_id_b;
  logic [15:0] res_count_a;
  logic [6:0]  res_count_b;
  logic        res_sat_a, res_sat_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  popcnt_job_sched #(.NREQ(2), .LAT(LAT), .CW(16), .IDW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_last(req_last), .req_data(req_data), .pc_in(pc_in_a), .pc_out(pc_out_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_id(res_id_a),
    .res_count(res_count_a), .res_sat(res_sat_a), .busy(busy_a)
  );

  popcnt_job_sched #(.NREQ(2), .LAT(LAT), .CW(7), .IDW(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_last(req_last), .req_data(req_data), .pc_in(pc_in_b), .pc_out(pc_out_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_id(res_id_b),
    .res_count(res_count_b), .res_sat(res_sat_b), .busy(busy_b)
  );

  // External counters: fixed latency, no reset, no handshake.
  logic [5:0] cnt_a [LAT];
  logic [5:0] cnt_b [LAT];
  always @(posedge clk) begin
    cnt_a[0] <= 6'($countones(pc_in_a));
    cnt_b[0] <= 6'($countones(pc_in_b));
    for (int i = 1; i < LAT; i++) begin
      cnt_a[i] <= cnt_a[i-1];
      cnt_b[i] <= cnt_b[i-1];
    end
  end
  assign pc_out_a = cnt_a[LAT-1];
  assign pc_out_b = cnt_b[LAT-1];

  int   cyc = 0;
  int   n_acc = 0;
  logic both_rdy = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if ((req_valid & req_ready_a) != 2'b00) n_acc <= n_acc + 1;
    if (req_ready_a == 2'b11 || req_ready_b == 2'b11) both_rdy <= 1'b1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy_a"},  req_ready_a, 0);
    chk({tag, "_pcin_a"}, pc_in_a, 0);
    chk({tag, "_rv_a"},   res_valid_a, 0);
    chk({tag, "_id_a"},   res_id_a, 0);
    chk({tag, "_cnt_a"},  res_count_a, 0);
    chk({tag, "_sat_a"},  res_sat_a, 0);
    chk({tag, "_busy_a"}, busy_a, 0);
    chk({tag, "_rv_b"},   res_valid_b, 0);
    chk({tag, "_busy_b"}, busy_b, 0);
  endtask

  // Starts and returns just after a rising edge; returns the edge count of the accept.
  task automatic drive_word(input int r, input logic [31:0] w, input logic last,
                            input int gap, output int acc_cyc);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    req_valid[r]          = 1'b1;
    req_data[32*r +: 32]  = w;
    req_last[r]           = last;
    t = 0;
    @(negedge clk);
    while (!req_ready_a[r] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    req_valid[r] = 1'b0;
    chk("pc_in", pc_in_a, w);
  endtask

  // Starts and returns just after a rising edge; completes the result handshake.
  task automatic take_res(input string tag, input int exp_id, input int exp_a,
                          input int exp_sa, input int exp_b, input int exp_sb,
                          output int seen_cyc);
    int t;
    t = 0;
    seen_cyc = 0;
    @(negedge clk);
    while (!res_valid_a && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      seen_cyc = cyc;
      chk({tag, "_id"},    res_id_a, exp_id);
      chk({tag, "_cnt"},   res_count_a, exp_a);
      chk({tag, "_sat"},   res_sat_a, exp_sa);
      chk({tag, "_rv_b"},  res_valid_b, 1);
      chk({tag, "_cnt_b"}, res_count_b, exp_b);
      chk({tag, "_sat_b"}, res_sat_b, exp_sb);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({tag, "_hs_drop"}, res_valid_a, 0);
  endtask

  initial begin
    int k, seen, n0, bad, t;
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    // Single back-to-back job on requester 0: 32 + 4 + 2.
    drive_word(0, 32'hFFFF_FFFF, 1'b0, 0, k);
    drive_word(0, 32'h0000_000F, 1'b0, 0, k);
    drive_word(0, 32'h8000_0001, 1'b1, 0, k);
    take_res("single", 0, 38, 0, 38, 0, seen);
    chk("single_lat", seen - k, LAT + 1);

    // Gapped job on requester 1: 1 + 2 + 3.
    n0 = n_acc;
    drive_word(1, 32'h0000_0001, 1'b0, 0, k);
    drive_word(1, 32'h0000_0003, 1'b0, 2, k);
    drive_word(1, 32'h0000_0007, 1'b1, 1, k);
    take_res("gap", 1, 6, 0, 6, 0, seen);
    chk("gap_tokens", n_acc - n0, 3);

    // Both requesters keep one-word jobs pending: grants alternate 0,1,0,1.
    req_data  = {32'h0000_FFFF, 32'hF0F0_F0F0};
    req_last  = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) take_res("rr", i % 2, 16, 0, 16, 0, seen);
    req_valid = 2'b00;
    chk("rr_excl", both_rdy, 0);

    // Backpressure: result held with requester 1 waiting.
    drive_word(0, 32'h0000_0003, 1'b1, 0, k);
    req_data[63:32] = 32'h0000_00FF;
    req_last[1]     = 1'b1;
    req_valid[1]    = 1'b1;
    t = 0;
    @(negedge clk);
    while (!res_valid_a && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("bp_wait", t < 300, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid_a !== 1'b1 || res_count_a !== 16'd2 || res_id_a !== 1'b0 ||
          res_sat_a !== 1'b0 || req_ready_a !== 2'b00 || busy_a !== 1'b1) bad++;
      if (i < 4) @(negedge clk);
    end
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_bubble_rdy", req_ready_a, 2'b00);
    chk("bp_bubble_busy", busy_a, 0);
    @(negedge clk);
    chk("bp_grant1", req_ready_a, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("bp_pc_in", pc_in_a, 32'h0000_00FF);
    take_res("bp_next", 1, 8, 0, 8, 0, seen);

    // Five all-ones words: 160 fits 16 bits, saturates 7 bits at 127.
    for (int i = 0; i < 5; i++) drive_word(0, 32'hFFFF_FFFF, (i == 4), 0, k);
    take_res("sat", 0, 160, 0, 127, 1, seen);

    // Reset during DRAIN while counts are still in flight.
    for (int i = 0; i < 4; i++) drive_word(0, 32'hFFFF_FFFF, (i == 3), 0, k);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("midrst");
    rst_n = 1'b1;
    drive_word(1, 32'h0000_000F, 1'b1, 0, k);
    take_res("postrst", 1, 4, 0, 4, 0, seen);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
